ps2_mouse_packer: RTL and testbench

//  Assembles raw PS/2 mouse bytes (from a PS/2 line receiver) into the 25-bit ps2_mouse word consumed by paddle_ctl.

---
 rtl/ps2_mouse_packer.sv | 121 ++++++++++++
 tb/tb_ps2_mouse_packer.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/ps2_mouse_packer.sv
// Packs PS/2 mouse bytes into the {toggle, dy, dx, status} word, with sync checking and an inter-byte timeout.
// Optional 4-byte IntelliMouse support (wheel_mode, ps2_wheel) is built when PS2_MOUSE_WHEEL_EN is defined.
module ps2_mouse_packer #(
  parameter int TIMEOUT_CYCLES = 100000,
  parameter int TO_W           = 17
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic [24:0] ps2_mouse,
  output logic [7:0]  sync_err_cnt
`ifdef PS2_MOUSE_WHEEL_EN
  ,
  input  logic        wheel_mode,
  output logic [7:0]  ps2_wheel
`endif
);

`ifdef PS2_MOUSE_WHEEL_EN
  typedef enum logic [2:0] {B0, B1, B2, B3, PUB} state_t;
`else
  typedef enum logic [2:0] {B0, B1, B2, PUB} state_t;
`endif

  localparam logic [TO_W-1:0] TO_MAX = TO_W'(TIMEOUT_CYCLES - 1);

  state_t          state, state_nxt;
  logic [TO_W-1:0] to_cnt;
  logic [7:0]      status_q, dx_q, dy_q;
  logic            accept, in_pkt, timeout, drop;
`ifdef PS2_MOUSE_WHEEL_EN
  logic [7:0]      z_q;
  logic            wheel_q;
`endif

  assign rx_ready = (state != PUB);
  assign accept   = rx_valid && rx_ready;
  assign in_pkt   = (state == B1) || (state == B2)
`ifdef PS2_MOUSE_WHEEL_EN
                    || (state == B3)
`endif
                    ;
  // An accepted byte in the expiry cycle beats the timeout.
  assign timeout  = in_pkt && !accept && (to_cnt == TO_MAX);

  always_comb begin
    state_nxt = state;
    drop      = 1'b0;
    if (timeout) begin
      state_nxt = B0;
    end else begin
      case (state)
        B0: if (accept) begin
          if (rx_data[3]) state_nxt = B1;
          else            drop      = 1'b1;
        end
        B1: if (accept) state_nxt = B2;
`ifdef PS2_MOUSE_WHEEL_EN
        B2: if (accept) state_nxt = wheel_q ? B3 : PUB;
        B3: if (accept) state_nxt = PUB;
`else
        B2: if (accept) state_nxt = PUB;
`endif
        PUB:     state_nxt = B0;
        default: state_nxt = B0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= B0;
      to_cnt       <= '0;
      status_q     <= '0;
      dx_q         <= '0;
      dy_q         <= '0;
      ps2_mouse    <= '0;
      sync_err_cnt <= '0;
`ifdef PS2_MOUSE_WHEEL_EN
      z_q          <= '0;
      wheel_q      <= 1'b0;
      ps2_wheel    <= '0;
`endif
    end else begin
      state <= state_nxt;

      if (!in_pkt || accept || timeout) to_cnt <= '0;
      else                              to_cnt <= to_cnt + 1'b1;

      if (accept) begin
        case (state)
          B0: if (rx_data[3]) begin
            status_q <= rx_data;
`ifdef PS2_MOUSE_WHEEL_EN
            wheel_q  <= wheel_mode;
`endif
          end
          B1: dx_q <= rx_data;
          B2: dy_q <= rx_data;
`ifdef PS2_MOUSE_WHEEL_EN
          B3: z_q  <= rx_data;
`endif
          default: ;
        endcase
      end

      if (state == PUB) begin
        ps2_mouse <= {~ps2_mouse[24], dy_q, dx_q, status_q};
`ifdef PS2_MOUSE_WHEEL_EN
        if (wheel_q) ps2_wheel <= z_q;
`endif
      end

      if ((drop || timeout) && (sync_err_cnt != 8'hFF))
        sync_err_cnt <= sync_err_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_ps2_mouse_packer.sv
// Scoreboard bench for ps2_mouse_packer: expected words are queued as packets are driven and popped on publish.
module tb_ps2_mouse_packer;
  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  rx_data = '0;
  logic        rx_valid = 1'b0;
  logic        rx_ready;
  logic [24:0] ps2_mouse;
  logic [7:0]  sync_err_cnt;
`ifdef PS2_MOUSE_WHEEL_EN
  logic        wheel_mode = 1'b0;
  logic [7:0]  ps2_wheel;
`endif

  ps2_mouse_packer #(.TIMEOUT_CYCLES(TO), .TO_W(5)) dut (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .ps2_mouse(ps2_mouse), .sync_err_cnt(sync_err_cnt)
`ifdef PS2_MOUSE_WHEEL_EN
    , .wheel_mode(wheel_mode), .ps2_wheel(ps2_wheel)
`endif
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          failures = 0;
  logic [24:0] sb_q[$];
  logic        exp_tog = 1'b0;
  int          exp_err = 0;
  int          exp_pkts = 0;
  int          seen_pkts = 0;
  logic        prev_tog = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Count publishes outside reset so partial packets that leak out are caught.
  always @(negedge clk) begin
    if (!reset && ps2_mouse[24] !== prev_tog) seen_pkts++;
    prev_tog = ps2_mouse[24];
  end

  task automatic push_pkt(input logic [7:0] s, input logic [7:0] dx, input logic [7:0] dy);
    sb_q.push_back({~exp_tog, dy, dx, s});
    exp_tog = ~exp_tog;
    exp_pkts++;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int waited;
    waited = 0;
    @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = b;
    while (!rx_ready && waited < 8) begin
      @(negedge clk);
      waited++;
    end
    if (!rx_ready) chk("rdy_wait_expired", 32'(rx_ready), 32'd1);
    @(posedge clk);
    #1 rx_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Called right after the final byte's accepting edge.
  task automatic check_pkt(input string tag);
    logic [24:0] exp;
    @(negedge clk);
    chk({tag, "_pub_rdy"}, 32'(rx_ready), 32'd0);
    @(negedge clk);
    chk({tag, "_rdy_back"}, 32'(rx_ready), 32'd1);
    if (sb_q.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'd0, 32'd1);
    end else begin
      exp = sb_q.pop_front();
      chk({tag, "_word"}, 32'(ps2_mouse), 32'(exp));
    end
    chk({tag, "_err"}, 32'(sync_err_cnt), 32'(exp_err));
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    exp_tog = 1'b0;
    exp_err = 0;
    sb_q.delete();
    #1;
    chk("rst_mouse", 32'(ps2_mouse), 32'd0);
    chk("rst_err", 32'(sync_err_cnt), 32'd0);
    chk("rst_rdy", 32'(rx_ready), 32'd1);
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    do_reset();

    push_pkt(8'h18, 8'h05, 8'hFB);
    send_byte(8'h18); send_byte(8'h05); send_byte(8'hFB);
    check_pkt("p1");

    push_pkt(8'h08, 8'h01, 8'h02);
    send_byte(8'h08); send_byte(8'h01); send_byte(8'h02);
    check_pkt("p2");

    exp_err++;
    push_pkt(8'h08, 8'h10, 8'h20);
    send_byte(8'h00); send_byte(8'h08); send_byte(8'h10); send_byte(8'h20);
    check_pkt("drop");

    // 16 idle cycles in B2 expire the partial packet.
    exp_err++;
    push_pkt(8'h09, 8'h22, 8'h33);
    send_byte(8'h08); send_byte(8'h11); idle(TO);
    send_byte(8'h09); send_byte(8'h22); send_byte(8'h33);
    check_pkt("tmo");

    // Byte arriving in the expiry cycle wins.
    push_pkt(8'h08, 8'h11, 8'h22);
    send_byte(8'h08); send_byte(8'h11); idle(TO - 1);
    send_byte(8'h22);
    check_pkt("edge");

    // Reset mid-packet.
    send_byte(8'h08); send_byte(8'h11);
    do_reset();
    push_pkt(8'h0A, 8'h01, 8'h01);
    send_byte(8'h0A); send_byte(8'h01); send_byte(8'h01);
    check_pkt("post_rst");
    chk("post_rst_tog", 32'(ps2_mouse[24]), 32'd1);

`ifdef PS2_MOUSE_WHEEL_EN
    wheel_mode = 1'b1;
    push_pkt(8'h08, 8'h03, 8'h04);
    send_byte(8'h08); send_byte(8'h03); send_byte(8'h04); send_byte(8'hFF);
    check_pkt("whl");
    chk("whl_z", 32'(ps2_wheel), 32'hFF);
    wheel_mode = 1'b0;
    push_pkt(8'h08, 8'h05, 8'h06);
    send_byte(8'h08); send_byte(8'h05); send_byte(8'h06);
    check_pkt("whl_off");
    chk("whl_keep", 32'(ps2_wheel), 32'hFF);
`endif

    // Saturation of the error counter.
    for (int i = 0; i < 260; i++) begin
      send_byte(8'h00);
      if (exp_err < 255) exp_err++;
      if (i == 100) chk("err_mid", 32'(sync_err_cnt), 32'(exp_err));
    end
    @(negedge clk);
    chk("err_sat", 32'(sync_err_cnt), 32'd255);
    chk("sat_word_kept", 32'(ps2_mouse[24]), 32'(exp_tog));

    repeat (3) @(negedge clk);
    chk("pkt_count", 32'(seen_pkts), 32'(exp_pkts));
    chk("sb_drained", 32'(sb_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule
